match_scan_ctrl: RTL
====================

# match_scan_ctrl

Sequencer for the template-match calculation unit. Steps the candidate start place across all scan positions and, for each one, drives the unit's startsig/work/valid/finalstart/change controls while the sample source streams f/g pairs. It then captures the 18-bit result and keeps the best result and its place. It sits between the top-level command interface and the calculation unit, and is the only driver of that unit's control inputs.

## Interface

Parameters:
- NPOS, 64: number of scan positions, 1..64; start places are 0..NPOS-1.
- WIN_LEN, 32: samples accumulated per position, 1..256.
- CALC_LAT, 2: cycles from the finalstart pulse until the unit's result is stable, 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle scan request; ignored unless idle.
- abort  in  1  return to idle; present only with SCAN_ABORT_EN.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan completes.
- smp_req  out  1  requests one f/g sample pair.
- smp_addr  out  14  sample index = startplace*256 + window count.
- smp_vld  in  1  sample pair present on the unit's fdata/gdata this cycle.
- startplace  out  6  current position, to the unit.
- startsig  out  1  one-cycle pulse; clears the unit's accumulators for startplace.
- work  out  1  high while a position is being processed.
- valid  out  1  accumulate-enable to the unit.
- finalstart  out  1  one-cycle pulse after the last sample.
- change  out  1  one-cycle pulse when advancing to the next position.
- result  in  18  unit result, unsigned.
- place  in  6  place echoed by the unit.
- best_result  out  18  best result of the last completed scan.
- best_place  out  6  place of best_result.

## Operation

- States:
  - IDLE: on start, go to INIT.
  - INIT: startsig=1, work=1; go to ACCUM.
  - ACCUM: count window samples; go to FINAL when the count reaches WIN_LEN.
  - FINAL: finalstart=1; go to WAIT.
  - WAIT: count CALC_LAT cycles; go to CMP.
  - CMP: compare and update the running best; go to INIT with change=1 if startplace<NPOS-1, else to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- ACCUM handshake:
  - smp_req=1 while cnt<WIN_LEN.
  - valid=smp_vld&smp_req, combinational; cnt increments only on valid.
  - smp_vld while smp_req=0 is ignored.
  - smp_vld may stay low indefinitely; the controller stalls with no timeout.
- Compare:
  - Default: update the running best when result < running best (minimum distance).
  - First position always loads.
  - Ties keep the earlier place, because the comparison is strict.
  - The running best comes from result and place. In CMP, if place≠startplace, still use startplace and set an internal mismatch flag (debug only).
- best_result/best_place are copied from the running best on entry to DONE. They hold until the next scan's DONE.
- start while busy is ignored. start in the DONE cycle is ignored.
- work is high in INIT through CMP and low in IDLE and DONE.
- change and startsig are never high in the same cycle. change occurs in CMP; startsig occurs in the following INIT, with startplace already incremented.

## Timing

- Reset values: every control output is 0, startplace=0, smp_addr=0, best_result=18'h3FFFF, best_place=0, state=IDLE.
- All outputs are registered except valid and smp_req, which are decoded from registered state.
- Per-position cycles = 1 (INIT) + WIN_LEN accepted samples + stall cycles + 1 (FINAL) + CALC_LAT + 1 (CMP).
- Full scan with no stalls = NPOS*(WIN_LEN+CALC_LAT+3) + 1 (DONE) cycles after start; busy is 1 for exactly that span.
- Reset mid-scan: immediate return to reset values. The unit's state is left as-is, and the next startsig clears it.

## Configuration

- SCAN_ABORT_EN:
  - Defined: the abort port exists. When abort=1 in any non-IDLE state, the next state is IDLE and busy/work drop next cycle. done is not pulsed and best_* are unchanged. Abort has priority over start in the same cycle.
  - Undefined: no abort port; a scan always runs to DONE.

## Test plan

- NPOS=4, WIN_LEN=8, CALC_LAT=2, smp_vld tied 1, results 900/500/700/500 -> best_result=500, best_place=1, done exactly 53 cycles after start, busy high 53 cycles.
- smp_vld toggling 1-0 during ACCUM -> valid count per position is exactly 8, smp_addr runs 256*p+0..7, finalstart exactly 1 cycle after the 8th accepted sample.
- start pulsed again during a scan, and also in the DONE cycle -> ignored, no second scan, single done pulse.
- rst_n asserted in WAIT of position 2 -> all outputs at reset values the same cycle; a fresh start produces a full scan from startplace 0.
- SCAN_ABORT_EN defined, abort in ACCUM of position 1 with start also high -> IDLE next cycle, no done, best_* keep the previous scan's value (or 3FFFF/0 after reset).
- NPOS=1, WIN_LEN=1, result 18'h3FFFF -> best_result=3FFFF, best_place=0, no change pulse.

Source files
------------

// File: rtl/match_scan_ctrl_if.sv
// Command and calculation-unit signal bundle for match_scan_ctrl.
// The abort input exists only when SCAN_ABORT_EN is defined.
interface match_scan_ctrl_if;
    logic        start;
`ifdef SCAN_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic        smp_req;
    logic [13:0] smp_addr;
    logic        smp_vld;
    logic [5:0]  startplace;
    logic        startsig;
    logic        work;
    logic        valid;
    logic        finalstart;
    logic        change;
    logic [17:0] result;
    logic [5:0]  place;
    logic [17:0] best_result;
    logic [5:0]  best_place;

    modport master (
        input  start, smp_vld, result, place,
        output busy, done, smp_req, smp_addr, startplace, startsig, work, valid,
               finalstart, change, best_result, best_place
`ifdef SCAN_ABORT_EN
        , input abort
`endif
    );

    modport slave (
        output start, smp_vld, result, place,
        input  busy, done, smp_req, smp_addr, startplace, startsig, work, valid,
               finalstart, change, best_result, best_place
`ifdef SCAN_ABORT_EN
        , output abort
`endif
    );
endinterface

// File: rtl/match_scan_ctrl.sv
// Scan sequencer for the template-match unit: walks every start place, streams a window
// of samples, and keeps the minimum result. SCAN_ABORT_EN enables the abort input.
module match_scan_ctrl #(
    parameter int unsigned NPOS     = 64,
    parameter int unsigned WIN_LEN  = 32,
    parameter int unsigned CALC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    match_scan_ctrl_if.master ctrl_io,
    output logic              dbg_mismatch_o
);
    typedef enum logic [2:0] {
        StIdle, StInit, StAccum, StFinal, StWait, StCmp, StDone
    } state_e;

    localparam logic [8:0] WinLen    = 9'(WIN_LEN);
    localparam logic [5:0] LastPlace = 6'(NPOS - 1);
    localparam logic [2:0] LastLat   = 3'(CALC_LAT - 1);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [2:0]  lat_q, lat_d;
    logic [5:0]  place_q, place_d;
    logic [17:0] run_q, run_d;
    logic [5:0]  run_place_q, run_place_d;
    logic [17:0] best_q, best_d;
    logic [5:0]  best_place_q, best_place_d;
    logic        mismatch_q, mismatch_d;
    logic        busy_q, done_q, startsig_q, work_q, finalstart_q, change_q;
    logic [13:0] smp_addr_q;
    logic        smp_req, valid, abort_req;

`ifdef SCAN_ABORT_EN
    assign abort_req = ctrl_io.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign smp_req = (state_q == StAccum) && (cnt_q < WinLen);
    assign valid   = smp_req & ctrl_io.smp_vld;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        place_d      = place_q;
        run_d        = run_q;
        run_place_d  = run_place_q;
        best_d       = best_q;
        best_place_d = best_place_q;
        mismatch_d   = mismatch_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (ctrl_io.start && !abort_req) begin
                    state_d    = StInit;
                    place_d    = '0;
                    mismatch_d = 1'b0;
                end
            end
            StInit: begin
                cnt_d   = '0;
                state_d = StAccum;
            end
            StAccum: begin
                if (valid) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == WinLen - 9'd1) state_d = StFinal;
                end
            end
            StFinal: begin
                lat_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == LastLat) state_d = StCmp;
                else                  lat_d   = lat_q + 3'd1;
            end
            StCmp: begin
                cnt_d = '0;
                // Strict less-than keeps the earlier place on ties; the first place always loads.
                if (place_q == 6'd0 || ctrl_io.result < run_q) begin
                    run_d       = ctrl_io.result;
                    run_place_d = place_q;
                end
                if (ctrl_io.place != place_q) mismatch_d = 1'b1;
                if (place_q == LastPlace) begin
                    state_d      = StDone;
                    best_d       = run_d;
                    best_place_d = run_place_d;
                end else begin
                    state_d = StInit;
                    place_d = place_q + 6'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_req && state_q != StIdle) begin
            state_d      = StIdle;
            best_d       = best_q;
            best_place_d = best_place_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            lat_q        <= '0;
            place_q      <= '0;
            run_q        <= '1;
            run_place_q  <= '0;
            best_q       <= '1;
            best_place_q <= '0;
            mismatch_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            startsig_q   <= 1'b0;
            work_q       <= 1'b0;
            finalstart_q <= 1'b0;
            change_q     <= 1'b0;
            smp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            place_q      <= place_d;
            run_q        <= run_d;
            run_place_q  <= run_place_d;
            best_q       <= best_d;
            best_place_q <= best_place_d;
            mismatch_q   <= mismatch_d;
            // Control outputs are registered from the next state so they align with it.
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StDone);
            startsig_q   <= (state_d == StInit);
            work_q       <= state_d inside {StInit, StAccum, StFinal, StWait, StCmp};
            finalstart_q <= (state_d == StFinal);
            change_q     <= (state_d == StCmp) && (place_d != LastPlace);
            smp_addr_q   <= {place_d, cnt_d[7:0]};
        end
    end

    assign ctrl_io.busy        = busy_q;
    assign ctrl_io.done        = done_q;
    assign ctrl_io.smp_req     = smp_req;
    assign ctrl_io.smp_addr    = smp_addr_q;
    assign ctrl_io.startplace  = place_q;
    assign ctrl_io.startsig    = startsig_q;
    assign ctrl_io.work        = work_q;
    assign ctrl_io.valid       = valid;
    assign ctrl_io.finalstart  = finalstart_q;
    assign ctrl_io.change      = change_q;
    assign ctrl_io.best_result = best_q;
    assign ctrl_io.best_place  = best_place_q;
    assign dbg_mismatch_o      = mismatch_q;
endmodule
